// File: rtl/lcd_writer.sv
// HD44780 8-bit write engine: power-on init, per-character en/rs strobing,
// automatic cursor wrap between the two 16-character lines.
module lcd_writer #(
    parameter int POWER_ON_CYCLES   = 750000,
    parameter int EN_PULSE_CYCLES   = 12,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 80000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       data_ready,
    input  logic [7:0] data_in,
    output logic       lcd_busy,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);
    localparam int MAX_A = (POWER_ON_CYCLES > EN_PULSE_CYCLES) ? POWER_ON_CYCLES : EN_PULSE_CYCLES;
    localparam int MAX_B = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1) + 1;

    localparam logic [2:0] POWER_WAIT = 3'd0;
    localparam logic [2:0] SETUP      = 3'd1;
    localparam logic [2:0] EN_HIGH    = 3'd2;
    localparam logic [2:0] EN_WAIT    = 3'd3;
    localparam logic [2:0] WRAP       = 3'd4;
    localparam logic [2:0] IDLE       = 3'd5;
    localparam logic [2:0] RELEASE    = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    init_idx;
    logic          in_init;
    logic [4:0]    cursor;
    logic [4:0]    cursor_nxt;
    logic          wait_done;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    assign lcd_rw     = 1'b0;
    assign cursor_nxt = cursor + 5'd1;
    // Clear-display needs the long settle time; every other byte uses the short one.
    assign wait_done  = (!lcd_rs && lcd_data == 8'h01) ? (cnt == CW'(CLEAR_WAIT_CYCLES - 1))
                                                       : (cnt == CW'(CMD_WAIT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= POWER_WAIT;
            cnt      <= '0;
            init_idx <= 2'd0;
            in_init  <= 1'b1;
            cursor   <= 5'd0;
            lcd_busy <= 1'b1;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (state)
                POWER_WAIT: begin
                    if (cnt == CW'(POWER_ON_CYCLES - 1)) begin
                        cnt      <= '0;
                        init_idx <= 2'd0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_cmd(2'd0);
                        state    <= SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETUP: begin
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                    state  <= EN_HIGH;
                end
                EN_HIGH: begin
                    if (cnt == CW'(EN_PULSE_CYCLES - 1)) begin
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                        state  <= EN_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EN_WAIT: begin
                    if (wait_done) begin
                        cnt <= '0;
                        if (in_init) begin
                            if (init_idx == 2'd3) begin
                                in_init  <= 1'b0;
                                lcd_busy <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                lcd_data <= init_cmd(init_idx + 2'd1);
                                state    <= SETUP;
                            end
                        end else if (lcd_rs) begin
                            // Character just landed: advance cursor, reposition on line change.
                            cursor <= cursor_nxt;
                            state  <= (cursor_nxt == 5'd16 || cursor_nxt == 5'd0) ? WRAP : RELEASE;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRAP: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= (cursor == 5'd16) ? 8'hC0 : 8'h80;
                    state    <= SETUP;
                end
                IDLE: begin
                    if (data_ready) begin
                        lcd_data <= data_in;
                        lcd_rs   <= 1'b1;
                        lcd_busy <= 1'b1;
                        state    <= SETUP;
                    end
                end
                RELEASE: begin
                    // Wait for the requester to drop data_ready so a held request is not rewritten.
                    if (!data_ready) begin
                        lcd_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    lcd_busy <= 1'b1;
                    lcd_en   <= 1'b0;
                    state    <= POWER_WAIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_writer.sv
// Scoreboard bench for lcd_writer: stimulus pushes the expected en pulses,
// a negedge monitor pops and compares each pulse as the DUT produces it.
module tb_lcd_writer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       data_ready;
    logic [7:0] data_in;
    logic       lcd_busy, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;
    logic [8:0] exp_q[$];

    lcd_writer #(
        .POWER_ON_CYCLES(20), .EN_PULSE_CYCLES(3),
        .CMD_WAIT_CYCLES(5), .CLEAR_WAIT_CYCLES(10)
    ) dut (
        .clock(clock), .reset_n(reset_n), .data_ready(data_ready), .data_in(data_in),
        .lcd_busy(lcd_busy), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: every character is one rs=1 pulse; crossing to cursor 16 or 0 adds a reposition command.
    task automatic model_char(input logic [7:0] ch);
        exp_q.push_back({1'b1, ch});
        cur = (cur + 1) % 32;
        if (cur == 16) exp_q.push_back({1'b0, 8'hC0});
        else if (cur == 0) exp_q.push_back({1'b0, 8'h80});
    endtask

    task automatic model_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic wait_busy(input logic v, input string name);
        for (int i = 0; i < 2000 && lcd_busy !== v; i++) tick();
        check(name, int'(lcd_busy), int'(v));
    endtask

    task automatic write_char(input logic [7:0] ch);
        wait_busy(1'b0, "wait_idle");
        data_in    = ch;
        data_ready = 1'b1;
        model_char(ch);
        tick();
        data_ready = 1'b0;
    endtask

    task automatic measure_init();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (lcd_busy && n < 200);
        check("init_latency", n, 61);
    endtask

    // Monitor: compare each en pulse against the head of the queue and check its width.
    initial begin
        logic en_prev;
        int hi_len;
        logic [8:0] e;
        en_prev = 1'b0;
        hi_len  = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                en_prev = 1'b0;
                hi_len  = 0;
            end else begin
                if (lcd_en && !en_prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pulse_unexpected: got rs=%0d data=0x%0h expected none", lcd_rs, lcd_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_rs", int'(lcd_rs), int'(e[8]));
                        check("pulse_data", int'(lcd_data), int'(e[7:0]));
                    end
                    hi_len = 1;
                end else if (lcd_en) begin
                    hi_len++;
                end else if (en_prev) begin
                    check("en_width", hi_len, 3);
                end
                en_prev = lcd_en;
            end
        end
    end

    initial begin
        int n;
        reset_n    = 1'b0;
        data_ready = 1'b0;
        data_in    = 8'h00;
        repeat (3) tick();
        check("rst_busy", int'(lcd_busy), 1);
        check("rst_en", int'(lcd_en), 0);
        check("rst_rs", int'(lcd_rs), 0);
        check("rst_data", int'(lcd_data), 0);
        check("rst_rw", int'(lcd_rw), 0);

        model_init();
        reset_n = 1'b1;
        measure_init();

        // Single character with exact accept/strobe timing.
        data_in    = 8'h41;
        data_ready = 1'b1;
        model_char(8'h41);
        tick();
        data_ready = 1'b0;
        check("acc_busy", int'(lcd_busy), 1);
        check("setup_en", int'(lcd_en), 0);
        tick();
        check("en_rise", int'(lcd_en), 1);
        n = 1;
        while (lcd_busy && n < 100) begin
            tick();
            n++;
        end
        check("char_latency", n, 10);

        // Held data_ready: one pulse only, busy until the request drops.
        data_in    = 8'h42;
        data_ready = 1'b1;
        model_char(8'h42);
        tick();
        check("held_acc", int'(lcd_busy), 1);
        repeat (25) tick();
        check("held_busy", int'(lcd_busy), 1);
        data_ready = 1'b0;
        tick();
        check("held_release", int'(lcd_busy), 0);

        // Fill both lines: wrap to line 2 and back to line 1.
        for (int i = 0; i < 30; i++) write_char(8'($urandom_range(255)));
        wait_busy(1'b0, "wrap_drain");
        repeat (2) tick();
        check("wrap_queue_empty", exp_q.size(), 0);

        // Controller-style handshake.
        for (int i = 0; i < 15; i++) begin
            wait_busy(1'b0, "ctl_idle");
            tick();
            data_in    = 8'h30 + 8'(i);
            data_ready = 1'b1;
            model_char(data_in);
            wait_busy(1'b1, "ctl_busy");
            tick();
            data_ready = 1'b0;
        end
        wait_busy(1'b0, "ctl_drain");
        repeat (2) tick();
        check("ctl_queue_empty", exp_q.size(), 0);

        // Reset while en is high.
        wait_busy(1'b0, "pre_rst_idle");
        data_in    = 8'h55;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        for (int i = 0; i < 50 && lcd_en !== 1'b1; i++) tick();
        check("pre_rst_en", int'(lcd_en), 1);
        reset_n = 1'b0;
        #1;
        check("async_en", int'(lcd_en), 0);
        check("async_busy", int'(lcd_busy), 1);
        exp_q.delete();
        cur = 0;
        repeat (2) tick();
        model_init();
        reset_n = 1'b1;
        measure_init();

        // Cursor restarted at 0: the 16th character wraps to line 2 again.
        for (int i = 0; i < 16; i++) write_char(8'($urandom_range(255)));
        wait_busy(1'b0, "final_drain");
        repeat (2) tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("rw_low", int'(lcd_rw), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
